// File: rtl/wb_regfile_if.sv
// Writeback/read bus between the MEM/WB stage, the decode stage and the register file.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              regwrite;
  logic              memtoreg;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] mem_alu_result;
  logic [ADDR_W-1:0] mem_write_reg;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] wb_data;
  logic              wb_fire;
  logic [31:0]       wb_count;
  logic [ADDR_W-1:0] last_wb_reg;

  modport master (
    output regwrite, memtoreg, read_data, mem_alu_result, mem_write_reg, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, wb_fire, wb_count, last_wb_reg
  );

  modport slave (
    input  regwrite, memtoreg, read_data, mem_alu_result, mem_write_reg, rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wb_fire, wb_count, last_wb_reg
  );
endinterface

// File: rtl/wb_regfile.sv
// Pipeline register file: two combinational read ports with writeback bypass,
// hardwired zero register, committed-write counter and last-destination tracking.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic          clk,
  input logic          rst_n,
  wb_regfile_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [31:0]       wb_count_q;
  logic [ADDR_W-1:0] last_q;
  logic              fire;
  logic [DATA_W-1:0] wdata;

  // Index 0 is never written, so its reset value keeps it reading zero.
  always_comb begin
    wdata = bus.memtoreg ? bus.read_data : bus.mem_alu_result;
    fire  = rst_n & bus.regwrite & (bus.mem_write_reg != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      wb_count_q <= '0;
      last_q     <= '0;
    end else if (fire) begin
      regs[bus.mem_write_reg] <= wdata;
      wb_count_q              <= wb_count_q + 32'd1;
      last_q                  <= bus.mem_write_reg;
    end
  end

  // Write-before-read: a read of the register being committed sees the new value now.
  always_comb begin
    bus.rs_data = '0;
    bus.rt_data = '0;
    if (rst_n && bus.rs_addr != '0)
      bus.rs_data = (fire && bus.rs_addr == bus.mem_write_reg) ? wdata : regs[bus.rs_addr];
    if (rst_n && bus.rt_addr != '0)
      bus.rt_data = (fire && bus.rt_addr == bus.mem_write_reg) ? wdata : regs[bus.rt_addr];
    bus.wb_data     = wdata;
    bus.wb_fire     = fire;
    bus.wb_count    = wb_count_q;
    bus.last_wb_reg = last_q;
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: scoreboard queue of expected values checked against a reference model.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] sb[$];
  logic [31:0] exp_v;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model [32];
  logic [31:0] m_cnt;
  logic [4:0]  m_last;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = '0;
    m_cnt = '0;
    m_last = '0;
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d);
    if (a != 5'd0) begin
      model[a] = d;
      m_cnt = m_cnt + 32'd1;
      m_last = a;
    end
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [4:0] wr,
                       input logic [4:0] rs, input logic [4:0] rt);
    bus.regwrite = we; bus.memtoreg = m2r; bus.read_data = rd;
    bus.mem_alu_result = alu; bus.mem_write_reg = wr; bus.rs_addr = rs; bus.rt_addr = rt;
  endtask

  task automatic test_reset();
    model_reset();
    drive(1'b1, 1'b1, 32'hCAFE_0001, 32'h0BAD_0002, 5'd4, 5'd4, 5'd0);
    #1;
    sb.push_back(32'd0); sb.push_back(32'd0); sb.push_back(32'd0);
    sb.push_back(32'd0); sb.push_back(32'd0); sb.push_back(32'hCAFE_0001);
    exp_v = sb.pop_front(); vectors++;
    if (bus.rs_data !== exp_v) begin miscompares++; $display("FAIL reset_rs: got %h want %h", bus.rs_data, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if (bus.rt_data !== exp_v) begin miscompares++; $display("FAIL reset_rt: got %h want %h", bus.rt_data, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if ({31'd0, bus.wb_fire} !== exp_v) begin miscompares++; $display("FAIL reset_fire: got %b want %h", bus.wb_fire, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if (bus.wb_count !== exp_v) begin miscompares++; $display("FAIL reset_count: got %h want %h", bus.wb_count, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if ({27'd0, bus.last_wb_reg} !== exp_v) begin miscompares++; $display("FAIL reset_last: got %h want %h", bus.last_wb_reg, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if (bus.wb_data !== exp_v) begin miscompares++; $display("FAIL reset_wbdata: got %h want %h", bus.wb_data, exp_v); end
    // Edge under reset must not commit anything.
    @(posedge clk); #1;
    sb.push_back(32'd0);
    exp_v = sb.pop_front(); vectors++;
    if (bus.wb_count !== exp_v) begin miscompares++; $display("FAIL reset_suppress: got %h want %h", bus.wb_count, exp_v); end
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    drive(1'b1, 1'b0, 32'h7777_7777, 32'h0000_1234, 5'd8, 5'd1, 5'd2);
    #1;
    sb.push_back(32'h0000_1234); sb.push_back(32'd1);
    exp_v = sb.pop_front(); vectors++;
    if (bus.wb_data !== exp_v) begin miscompares++; $display("FAIL alu_wbdata: got %h want %h", bus.wb_data, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if ({31'd0, bus.wb_fire} !== exp_v) begin miscompares++; $display("FAIL alu_fire: got %b want %h", bus.wb_fire, exp_v); end
    model_write(5'd8, 32'h0000_1234);
    @(posedge clk); #1;
    bus.regwrite = 1'b0; bus.rs_addr = 5'd8;
    #1;
    sb.push_back(model[8]); sb.push_back(m_cnt); sb.push_back({27'd0, m_last});
    exp_v = sb.pop_front(); vectors++;
    if (bus.rs_data !== exp_v) begin miscompares++; $display("FAIL alu_reg8: got %h want %h", bus.rs_data, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if (bus.wb_count !== exp_v) begin miscompares++; $display("FAIL alu_count: got %h want %h", bus.wb_count, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if ({27'd0, bus.last_wb_reg} !== exp_v) begin miscompares++; $display("FAIL alu_last: got %h want %h", bus.last_wb_reg, exp_v); end
  endtask

  task automatic test_load_bypass();
    @(negedge clk);
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 5'd9, 5'd9, 5'd8);
    #1;
    sb.push_back(32'hDEAD_BEEF); sb.push_back(model[8]);
    exp_v = sb.pop_front(); vectors++;
    if (bus.rs_data !== exp_v) begin miscompares++; $display("FAIL bypass_rs: got %h want %h", bus.rs_data, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if (bus.rt_data !== exp_v) begin miscompares++; $display("FAIL bypass_rt_other: got %h want %h", bus.rt_data, exp_v); end
    model_write(5'd9, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    bus.regwrite = 1'b0;
    #1;
    sb.push_back(model[9]); sb.push_back({27'd0, m_last});
    exp_v = sb.pop_front(); vectors++;
    if (bus.rs_data !== exp_v) begin miscompares++; $display("FAIL load_reg9: got %h want %h", bus.rs_data, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if ({27'd0, bus.last_wb_reg} !== exp_v) begin miscompares++; $display("FAIL load_last: got %h want %h", bus.last_wb_reg, exp_v); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    #1;
    sb.push_back(32'd0); sb.push_back(32'd0); sb.push_back(32'd0);
    exp_v = sb.pop_front(); vectors++;
    if ({31'd0, bus.wb_fire} !== exp_v) begin miscompares++; $display("FAIL zero_fire: got %b want %h", bus.wb_fire, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if (bus.rs_data !== exp_v) begin miscompares++; $display("FAIL zero_rs: got %h want %h", bus.rs_data, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if (bus.rt_data !== exp_v) begin miscompares++; $display("FAIL zero_rt: got %h want %h", bus.rt_data, exp_v); end
    @(posedge clk); #1;
    bus.regwrite = 1'b0;
    #1;
    sb.push_back(m_cnt); sb.push_back(32'd0); sb.push_back({27'd0, m_last});
    exp_v = sb.pop_front(); vectors++;
    if (bus.wb_count !== exp_v) begin miscompares++; $display("FAIL zero_count: got %h want %h", bus.wb_count, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if (bus.rs_data !== exp_v) begin miscompares++; $display("FAIL zero_after: got %h want %h", bus.rs_data, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if ({27'd0, bus.last_wb_reg} !== exp_v) begin miscompares++; $display("FAIL zero_last: got %h want %h", bus.last_wb_reg, exp_v); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0011, 5'd5, 5'd5, 5'd5);
    model_write(5'd5, 32'h11);
    @(negedge clk);
    bus.mem_alu_result = 32'h0000_0022;
    #1;
    sb.push_back(32'h11);
    exp_v = sb.pop_front(); vectors++;
    if (dut.regs[5] !== exp_v) begin miscompares++; $display("FAIL b2b_first: got %h want %h", dut.regs[5], exp_v); end
    sb.push_back(32'h22);
    exp_v = sb.pop_front(); vectors++;
    if (bus.rs_data !== exp_v) begin miscompares++; $display("FAIL b2b_bypass: got %h want %h", bus.rs_data, exp_v); end
    model_write(5'd5, 32'h22);
    @(posedge clk); #1;
    bus.regwrite = 1'b0;
    #1;
    sb.push_back(model[5]); sb.push_back(model[5]); sb.push_back(m_cnt);
    exp_v = sb.pop_front(); vectors++;
    if (bus.rs_data !== exp_v) begin miscompares++; $display("FAIL b2b_rs: got %h want %h", bus.rs_data, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if (bus.rt_data !== exp_v) begin miscompares++; $display("FAIL b2b_rt: got %h want %h", bus.rt_data, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if (bus.wb_count !== exp_v) begin miscompares++; $display("FAIL b2b_count: got %h want %h", bus.wb_count, exp_v); end
  endtask

  task automatic test_x_memtoreg();
    @(negedge clk);
    drive(1'b0, 1'bx, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 5'd5, 5'd5, 5'd9);
    @(posedge clk); #1;
    sb.push_back(model[5]); sb.push_back(model[9]); sb.push_back(m_cnt);
    exp_v = sb.pop_front(); vectors++;
    if (bus.rs_data !== exp_v) begin miscompares++; $display("FAIL xm2r_rs: got %h want %h", bus.rs_data, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if (bus.rt_data !== exp_v) begin miscompares++; $display("FAIL xm2r_rt: got %h want %h", bus.rt_data, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if (bus.wb_count !== exp_v) begin miscompares++; $display("FAIL xm2r_count: got %h want %h", bus.wb_count, exp_v); end
    bus.memtoreg = 1'b0;
  endtask

  task automatic test_random();
    logic [4:0]  wr, rs, rt;
    logic [31:0] rd, alu;
    logic        we, m2r;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      we = ($urandom_range(0, 3) != 0); m2r = $urandom_range(0, 1) == 1;
      rd = $urandom; alu = $urandom;
      wr = 5'($urandom_range(0, 31)); rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31));
      drive(we, m2r, rd, alu, wr, rs, rt);
      #1;
      if (we) model_write(wr, m2r ? rd : alu);
      sb.push_back(model[rs]); sb.push_back(model[rt]);
      exp_v = sb.pop_front(); vectors++;
      if (bus.rs_data !== exp_v) begin miscompares++; $display("FAIL rand_rs[%0d]: got %h want %h", n, bus.rs_data, exp_v); end
      exp_v = sb.pop_front(); vectors++;
      if (bus.rt_data !== exp_v) begin miscompares++; $display("FAIL rand_rt[%0d]: got %h want %h", n, bus.rt_data, exp_v); end
      @(posedge clk); #1;
      sb.push_back(m_cnt); sb.push_back({27'd0, m_last});
      exp_v = sb.pop_front(); vectors++;
      if (bus.wb_count !== exp_v) begin miscompares++; $display("FAIL rand_count[%0d]: got %h want %h", n, bus.wb_count, exp_v); end
      exp_v = sb.pop_front(); vectors++;
      if ({27'd0, bus.last_wb_reg} !== exp_v) begin miscompares++; $display("FAIL rand_last[%0d]: got %h want %h", n, bus.last_wb_reg, exp_v); end
    end
    bus.regwrite = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0055, 5'd3, 5'd3, 5'd3);
    model_write(5'd3, 32'h55);
    @(posedge clk); #1;
    bus.regwrite = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    sb.push_back(model[3]); sb.push_back(m_cnt); sb.push_back({27'd0, m_last});
    exp_v = sb.pop_front(); vectors++;
    if (dut.regs[3] !== exp_v) begin miscompares++; $display("FAIL areset_reg3: got %h want %h", dut.regs[3], exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if (bus.wb_count !== exp_v) begin miscompares++; $display("FAIL areset_count: got %h want %h", bus.wb_count, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if ({27'd0, bus.last_wb_reg} !== exp_v) begin miscompares++; $display("FAIL areset_last: got %h want %h", bus.last_wb_reg, exp_v); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    sb.push_back(32'd0);
    exp_v = sb.pop_front(); vectors++;
    if (bus.rs_data !== exp_v) begin miscompares++; $display("FAIL areset_read3: got %h want %h", bus.rs_data, exp_v); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.wb_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count_q;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    sb.push_back(m_cnt);
    exp_v = sb.pop_front(); vectors++;
    if (bus.wb_count !== exp_v) begin miscompares++; $display("FAIL wrap_preload: got %h want %h", bus.wb_count, exp_v); end
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0777, 5'd7, 5'd7, 5'd0);
    model_write(5'd7, 32'h777);
    @(posedge clk); #1;
    bus.regwrite = 1'b0;
    #1;
    sb.push_back(m_cnt); sb.push_back(model[7]);
    exp_v = sb.pop_front(); vectors++;
    if (bus.wb_count !== exp_v) begin miscompares++; $display("FAIL wrap_count: got %h want %h", bus.wb_count, exp_v); end
    exp_v = sb.pop_front(); vectors++;
    if (bus.rs_data !== exp_v) begin miscompares++; $display("FAIL wrap_reg7: got %h want %h", bus.rs_data, exp_v); end
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    test_reset();
    test_alu();
    test_load_bypass();
    test_zero_reg();
    test_back_to_back();
    test_x_memtoreg();
    test_random();
    test_async_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
